// File: rtl/sgpio_frame_slave.sv
// sgpio_frame_slave: oversampled SGPIO slave, deserialises BMC frames to data_out and serialises data_in back on sdout.
module sgpio_frame_slave #(
  parameter int NUM_BITS = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 250000,
  parameter logic [NUM_BITS-1:0] OUT_RST_VAL = '0
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                sclk,
  input  logic                sload_n,
  input  logic                sdin,
  output logic                sdout,
  input  logic [NUM_BITS-1:0] data_in,
  output logic [NUM_BITS-1:0] data_out,
  output logic                frame_valid,
  output logic                frame_err,
  output logic                link_up
);
  localparam int CW = $clog2(NUM_BITS + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [SYNC_STAGES-1:0] sclk_q, sload_q, sdin_q;
  logic sclk_dly_q, rise_data_q, sdout_q, fv_q, fe_q, link_q;
  logic [NUM_BITS-1:0] shift_in_q, shift_out_q, data_out_q;
  logic [CW-1:0] bit_cnt_q;
  logic [TW-1:0] to_q;
  logic rise, fall, to_hit, sload_s, sdin_s;
  assign sload_s = sload_q[SYNC_STAGES-1];
  assign sdin_s = sdin_q[SYNC_STAGES-1];
  assign rise = sclk_q[SYNC_STAGES-1] & ~sclk_dly_q;
  assign fall = ~sclk_q[SYNC_STAGES-1] & sclk_dly_q;
  // a rise in the same clk always clears the counter, so a marker beats a timeout
  assign to_hit = !rise && to_q == TW'(TIMEOUT_CYC - 1);
  assign sdout = sdout_q;
  assign data_out = data_out_q;
  assign frame_valid = fv_q;
  assign frame_err = fe_q;
  assign link_up = link_q;
  always_ff @(posedge clk) begin
    if (srst) begin
      sclk_q <= '0;
      sload_q <= '1;
      sdin_q <= '0;
      sclk_dly_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sload_q <= {sload_q[SYNC_STAGES-2:0], sload_n};
      sdin_q <= {sdin_q[SYNC_STAGES-2:0], sdin};
      sclk_dly_q <= sclk_q[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      shift_in_q <= '0;
      shift_out_q <= '0;
      data_out_q <= OUT_RST_VAL;
      bit_cnt_q <= '0;
      to_q <= '0;
      rise_data_q <= 1'b0;
      sdout_q <= 1'b0;
      fv_q <= 1'b0;
      fe_q <= 1'b0;
      link_q <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      fe_q <= 1'b0;
      if (rise) to_q <= '0;
      else if (to_q != TW'(TIMEOUT_CYC)) to_q <= to_q + TW'(1);
      if (rise && sload_s) begin
        shift_in_q <= {sdin_s, shift_in_q[NUM_BITS-1:1]};
        if (bit_cnt_q != CW'(NUM_BITS + 1)) bit_cnt_q <= bit_cnt_q + CW'(1);
        rise_data_q <= 1'b1;
      end else if (rise) begin
        if (bit_cnt_q == CW'(NUM_BITS)) begin
          data_out_q <= shift_in_q;
          fv_q <= 1'b1;
          link_q <= 1'b1;
        end else fe_q <= 1'b1;
        bit_cnt_q <= '0;
        shift_out_q <= data_in;
        sdout_q <= data_in[0];
        rise_data_q <= 1'b0;
      end else if (fall && rise_data_q) begin
        shift_out_q <= {1'b0, shift_out_q[NUM_BITS-1:1]};
        sdout_q <= shift_out_q[1];
        rise_data_q <= 1'b0;
      end
      if (to_hit) begin
        data_out_q <= OUT_RST_VAL;
        link_q <= 1'b0;
        bit_cnt_q <= '0;
        fe_q <= 1'b1;
      end
    end
  end
endmodule
